alu_issue_seq: RTL and testbench

//  Issue/writeback sequencer sitting directly upstream and downstream of the 8-bit ALU.
//  It accepts one instruction at a time on a valid/ready handshake.
//  It reads operands from a small register file, or takes an immediate.
//  It drives the ALU opcode/operand inputs and captures alu_out back into the register file.
//  The ALU remains purely combinational; this block supplies all sequencing around it.

---
 rtl/alu_issue_seq_pkg.sv | 26 ++
 rtl/alu_issue_seq_regfile.sv | 37 +++
 rtl/alu_issue_seq.sv | 83 ++++++++
 tb/tb_alu_issue_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_seq_pkg.sv
// Shared widths, instruction field positions and FSM encoding for the ALU issue/writeback sequencer.
package alu_issue_seq_pkg;
  localparam int DATA_W  = 8;
  localparam int OP_W    = 3;
  localparam int NREG    = 4;
  localparam int RIDX_W  = $clog2(NREG);
  localparam int INSTR_W = 16;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int IMM_SEL = 12;
  localparam int DST_HI  = 11;
  localparam int DST_LO  = 10;
  localparam int SRCA_HI = 9;
  localparam int SRCA_LO = 8;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;
  localparam int SRCB_HI = 1;
  localparam int SRCB_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;
endpackage

// File: rtl/alu_issue_seq_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one write port where
// the writeback beats a preload, so a same-edge preload to the same register is lost.
module alu_issue_seq_regfile
  import alu_issue_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [RIDX_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [RIDX_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [RIDX_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  logic [DATA_W-1:0] rf_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      // Different addresses on the same edge both land; same address keeps the WB value.
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && wb_addr == RIDX_W'(i))
          rf_q[i] <= wb_data;
        else if (ld_en && ld_addr == RIDX_W'(i))
          rf_q[i] <= ld_data;
      end
    end
  end

  assign rd_a_data = rf_q[rd_a_addr];
  assign rd_b_data = rf_q[rd_b_addr];
endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer around a combinational ALU: IDLE accepts one instruction,
// EXEC lets the ALU settle and captures its output, WB writes it back to the register file.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ld_en,
  input  logic [RIDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic [OP_W-1:0]    alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               result_valid,
  output logic [DATA_W-1:0]  result,
  output logic [RIDX_W-1:0]  result_dst,
  output logic               busy
);
  state_e            state_q;
  logic [OP_W-1:0]   alu_opcode_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
  logic [RIDX_W-1:0] dst_q, result_dst_q;
  logic [DATA_W-1:0] rd_a_data, rd_b_data;

  alu_issue_seq_regfile u_rf (
    .clk       (clk),
    .reset     (reset),
    .rd_a_addr (instr[SRCA_HI:SRCA_LO]),
    .rd_a_data (rd_a_data),
    .rd_b_addr (instr[SRCB_HI:SRCB_LO]),
    .rd_b_data (rd_b_data),
    .wb_en     (state_q == ST_WB),
    .wb_addr   (result_dst_q),
    .wb_data   (result_q),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      dst_q        <= '0;
      result_q     <= '0;
      result_dst_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            alu_opcode_q <= instr[OP_HI:OP_LO];
            alu_a_q      <= rd_a_data;
            alu_b_q      <= instr[IMM_SEL] ? instr[IMM_HI:IMM_LO] : rd_b_data;
            dst_q        <= instr[DST_HI:DST_LO];
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q     <= alu_result;
          result_dst_q <= dst_q;
          state_q      <= ST_WB;
        end
        ST_WB:   state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_WB);
  assign alu_opcode   = alu_opcode_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign result       = result_q;
  assign result_dst   = result_dst_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural 8-bit ALU wired beside it.
module tb_alu_issue_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        ld_en = 1'b0;
  logic [1:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic        result_valid;
  logic [7:0]  result;
  logic [1:0]  result_dst;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: add, sub, and, or, xor, not a, shl, shr (carry dropped).
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~alu_a;
      3'b110: alu_result = alu_a << 1;
      default: alu_result = alu_a >> 1;
    endcase
  end

  alu_issue_seq dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .result_valid (result_valid),
    .result       (result),
    .result_dst   (result_dst),
    .busy         (busy)
  );

  function automatic logic [15:0] mk(input logic [2:0] op, input logic imm_sel,
                                     input logic [1:0] dst, input logic [1:0] src_a,
                                     input logic [7:0] b);
    return {op, imm_sel, dst, src_a, b};
  endfunction

  function automatic logic [31:0] rf_all();
    return {dut.u_rf.rf_q[3], dut.u_rf.rf_q[2], dut.u_rf.rf_q[1], dut.u_rf.rf_q[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tasks assume the caller sits at a falling edge and leave it at the next one.
  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    $display("txn instr=%h op=%0d a=%h b=%h", ins, alu_opcode, alu_a, alu_b);
  endtask

  logic [7:0] sweep_exp [8];
  int pulses;

  initial begin
    sweep_exp = '{8'h00, 8'hFE, 8'h01, 8'hFF, 8'hFE, 8'h00, 8'hFE, 8'h7F};

    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_alu", {8'b0, alu_opcode[2:0], 5'b0, alu_a, alu_b}, 32'd0);
    chk("rst_rf", rf_all(), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_result", {22'b0, result_dst, result, 1'b0, result_valid}, 32'd0);

    // 1: register-register add
    preload(2'd1, 8'h03);
    preload(2'd2, 8'h01);
    issue(mk(3'b000, 1'b0, 2'd0, 2'd1, 8'h02));
    chk("t1_exec", {8'b0, 5'b0, alu_opcode, alu_a, alu_b}, {16'b0, 8'h03, 8'h01});
    chk("t1_busy", {30'b0, busy, instr_ready}, 32'd2);
    @(negedge clk);
    chk("t1_wb", {22'b0, result_dst, result, 1'b0, result_valid}, {22'b0, 2'd0, 8'h04, 2'b01});
    @(negedge clk);
    chk("t1_idle", {30'b0, result_valid, instr_ready}, 32'd1);
    chk("t1_r0", {24'b0, dut.u_rf.rf_q[0]}, 32'h04);

    // 2: immediate subtract into r3
    issue(mk(3'b001, 1'b1, 2'd3, 2'd1, 8'h05));
    chk("t2_exec", {16'b0, alu_a, alu_b}, {16'b0, 8'h03, 8'h05});
    @(negedge clk);
    chk("t2_wb", {22'b0, result_dst, result, 2'b0}, {22'b0, 2'd3, 8'hFE, 2'b0});
    @(negedge clk);
    chk("t2_rf", rf_all(), 32'hFE_01_03_04);

    // 3: dependent pair with valid held high; B waits out A's two busy cycles
    instr = mk(3'b100, 1'b0, 2'd2, 2'd1, 8'h03); instr_valid = 1'b1;
    @(negedge clk);
    chk("t3a_exec", {5'b0, alu_opcode, instr_ready, 7'b0, alu_a, alu_b}, {5'b0, 3'd4, 1'b0, 7'b0, 8'h03, 8'hFE});
    instr = mk(3'b000, 1'b0, 2'd1, 2'd2, 8'h02);
    @(negedge clk);
    chk("t3a_wb", {23'b0, instr_ready, result}, {23'b0, 1'b0, 8'hFD});
    @(negedge clk);
    chk("t3_ready_back", {31'b0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("t3b_exec", {16'b0, alu_a, alu_b}, {16'b0, 8'hFD, 8'hFD});
    @(negedge clk);
    chk("t3b_wb", {22'b0, result_dst, result, 2'b0}, {22'b0, 2'd1, 8'hFA, 2'b0});
    @(negedge clk);

    // 4: preload during EXEC, same-register preload on the WB edge
    issue(mk(3'b010, 1'b0, 2'd3, 2'd1, 8'h02));
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h77;
    @(negedge clk);
    chk("t4_latched", {16'b0, alu_a, result}, {16'b0, 8'hFA, 8'hF8});
    ld_addr = 2'd3; ld_data = 8'hAA;
    @(negedge clk);
    ld_en = 1'b0;
    chk("t4_wb_wins", rf_all(), 32'hF8_FD_77_04);
    // different-address preload on the WB edge
    issue(mk(3'b011, 1'b1, 2'd2, 2'd0, 8'h10));
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h55;
    @(negedge clk);
    ld_en = 1'b0;
    chk("t4_both", rf_all(), 32'hF8_14_77_55);

    // 5: reset during EXEC
    issue(mk(3'b000, 1'b0, 2'd0, 2'd1, 8'h02));
    chk("t5_exec_busy", {31'b0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_out", {7'b0, busy, 5'b0, alu_opcode, alu_a, alu_b}, 32'd0);
    chk("t5_rst_rf", rf_all(), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    chk("t5_no_pulse", pulses, 32'd0);
    preload(2'd1, 8'h12);
    preload(2'd2, 8'h34);
    issue(mk(3'b000, 1'b0, 2'd0, 2'd1, 8'h02));
    @(negedge clk);
    chk("t5_after", {23'b0, result_valid, result}, {23'b0, 1'b1, 8'h46});
    @(negedge clk);

    // 6: opcode sweep with a = FF, b = 01
    preload(2'd1, 8'hFF);
    preload(2'd2, 8'h01);
    for (int op = 0; op < 8; op++) begin
      pulses = 0;
      issue(mk(3'(op), 1'b0, 2'd3, 2'd1, 8'h02));
      if (result_valid) pulses++;
      @(negedge clk);
      if (result_valid) pulses++;
      chk($sformatf("t6_op%0d", op), {24'b0, result}, {24'b0, sweep_exp[op]});
      @(negedge clk);
      if (result_valid) pulses++;
      chk($sformatf("t6_pulse%0d", op), pulses, 32'd1);
    end
    chk("t6_r3", {24'b0, dut.u_rf.rf_q[3]}, 32'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
